// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side signal bundle for alu_issue_ctrl.
// master = request source / ALU / result consumer side, slave = issue controller.
interface alu_issue_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [1:0]    in_a;
  logic [1:0]    in_b;
  logic [1:0]    alu_a;
  logic [1:0]    alu_b;
  logic [1:0]    alu_sel;
  logic [3:0]    alu_y;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_y;
  logic [1:0]    out_sel;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_sel, in_a, in_b, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, count
  );

  modport slave (
    input  in_valid, in_sel, in_a, in_b, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 2-bit ALU: request FIFO, one-at-a-time issue to the
// combinational ALU, and a valid/ready result register.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  alu_issue_ctrl_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          avail_q, avail_d;
  logic [1:0]    alu_a_q, alu_a_d;
  logic [1:0]    alu_b_q, alu_b_d;
  logic [1:0]    alu_sel_q, alu_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_y_q, out_y_d;
  logic [1:0]    out_sel_q, out_sel_d;

  logic in_ready;
  logic push;
  logic pop;
  logic capture;
  logic release_out;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // avail_q is occupancy delayed by one cycle, so a push into an empty FIFO
  // is seen by the FSM one cycle later (no bypass).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (avail_q) state_d = EXEC;
      EXEC:    state_d = WAIT;
      WAIT:    if (bus.out_ready) state_d = avail_q ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    unique case (state_q)
      IDLE: pop = avail_q;
      EXEC: capture = 1'b1;
      WAIT: begin
        release_out = bus.out_ready;
        pop         = bus.out_ready & avail_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_sel_d   = out_sel_q;
    avail_d     = (count_q != '0);
    count_d     = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_sel, bus.in_a, bus.in_b};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      {alu_sel_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
      rd_ptr_d                      = rd_ptr_q + 1'b1;
    end
    if (capture) begin
      out_y_d     = bus.alu_y;
      out_sel_d   = alu_sel_q;
      out_valid_d = 1'b1;
    end else if (release_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      avail_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sel_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      avail_q     <= avail_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed latency/full/reset cases,
// a vector table, and randomized traffic against an in-order result queue.
module tb_alu_issue_ctrl;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;
  logic rand_run = 1'b0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [1:0] sel;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] y;
  } vec_t;

  vec_t tbl [8];

  alu_issue_ctrl_if #(.DEPTH(DEPTH)) bus ();

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference ALU: ~A and ~(A&B) are 2-bit complements (3 - x), zero-extended.
  function automatic logic [3:0] alu_model(input logic [1:0] s, input logic [1:0] a,
                                           input logic [1:0] b);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (s)
      2'd0:    return 4'(3 - ia);
      2'd1:    return 4'(3 - int'(a & b));
      2'd2:    return 4'(ia + ib);
      default: return 4'(ia * ib);
    endcase
  endfunction

  assign bus.alu_y = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_req(input logic [1:0] s, input logic [1:0] a, input logic [1:0] b);
    bus.in_valid = 1'b1;
    bus.in_sel   = s;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL push_timeout: got in_ready=0 expected 1 within 300 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_q.size() == 0 && !bus.out_valid && bus.count == 0) begin
        check("drain_count", int'(bus.count), 0);
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: got pending=%0d count=%0d expected 0", exp_q.size(), bus.count);
  endtask

  task automatic monitor();
    logic       pv;
    logic       pr;
    logic [3:0] py;
    logic [1:0] ps;
    pv = 1'b0;
    pr = 1'b0;
    py = '0;
    ps = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (rst) begin
        exp_q.delete();
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_y", int'(bus.out_y), int'(py));
        check("hold_sel", int'(bus.out_sel), int'(ps));
      end
      check("in_ready_vs_count", int'(bus.in_ready), int'(bus.count < DEPTH));
      check("count_max", int'(bus.count <= DEPTH), 1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result: got out_y=%0d expected no result", bus.out_y);
        end else begin
          check("model_y", int'(bus.out_y), int'(exp_q[0][3:0]));
          check("model_sel", int'(bus.out_sel), int'(exp_q[0][5:4]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_sel, alu_model(bus.in_sel, bus.in_a, bus.in_b)});
      pv = bus.out_valid;
      pr = bus.out_ready;
      py = bus.out_y;
      ps = bus.out_sel;
    end
  endtask

  initial begin
    tbl[0] = '{2'b10, 2'd3, 2'd2, 4'd5};
    tbl[1] = '{2'b11, 2'd3, 2'd3, 4'd9};
    tbl[2] = '{2'b00, 2'd1, 2'd0, 4'd2};
    tbl[3] = '{2'b01, 2'd3, 2'd1, 4'd2};
    tbl[4] = '{2'b00, 2'd0, 2'd0, 4'd3};
    tbl[5] = '{2'b10, 2'd3, 2'd3, 4'd6};
    tbl[6] = '{2'b11, 2'd2, 2'd3, 4'd6};
    tbl[7] = '{2'b01, 2'd2, 2'd1, 4'd3};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_count", int'(bus.count), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_y", int'(bus.out_y), 0);
    check("rst_alu_sel", int'(bus.alu_sel), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    fork
      monitor();
    join_none

    // Single request: alu_* at N+2, out_valid after N+3.
    bus.out_ready = 1'b1;
    push_req(2'b10, 2'd3, 2'd2);
    check("t1_count_n", int'(bus.count), 1);
    check("t1_alu_sel_n", int'(bus.alu_sel), 0);
    tick();
    check("t1_alu_sel_n1", int'(bus.alu_sel), 0);
    check("t1_valid_n1", int'(bus.out_valid), 0);
    tick();
    check("t1_alu_sel_n2", int'(bus.alu_sel), 2);
    check("t1_alu_a_n2", int'(bus.alu_a), 3);
    check("t1_alu_b_n2", int'(bus.alu_b), 2);
    check("t1_valid_n2", int'(bus.out_valid), 0);
    tick();
    check("t1_valid_n3", int'(bus.out_valid), 1);
    check("t1_out_y", int'(bus.out_y), 5);
    check("t1_out_sel", int'(bus.out_sel), 2);
    drain();

    // Vector table pushed back-to-back; results in order, 2 cycles apart.
    fork
      begin
        for (int i = 0; i < 8; i++) push_req(tbl[i].sel, tbl[i].a, tbl[i].b);
      end
      begin
        int t;
        int last;
        t    = 0;
        last = 0;
        for (int i = 0; i < 8; i++) begin
          int k;
          for (k = 0; k < 100; k++) begin
            @(negedge clk);
            t++;
            if (bus.out_valid && bus.out_ready) break;
          end
          if (k == 100) begin
            checks++;
            failures++;
            $display("FAIL tbl_timeout: got no result expected vector %0d", i);
          end else begin
            check("tbl_y", int'(bus.out_y), int'(tbl[i].y));
            check("tbl_sel", int'(bus.out_sel), int'(tbl[i].sel));
            if (i > 0) check("tbl_spacing", t - last, 2);
            last = t;
          end
        end
      end
    join
    drain();

    // Backpressure: fill with out_ready=0, then pop while a push waits.
    bus.out_ready = 1'b0;
    push_req(2'b11, 2'd2, 2'd3);
    push_req(2'b10, 2'd1, 2'd1);
    push_req(2'b00, 2'd2, 2'd0);
    push_req(2'b01, 2'd1, 2'd1);
    push_req(2'b11, 2'd3, 2'd1);
    for (int i = 0; i < 3; i++) begin
      check("full_count", int'(bus.count), DEPTH);
      check("full_in_ready", int'(bus.in_ready), 0);
      check("full_out_valid", int'(bus.out_valid), 1);
      check("full_out_y", int'(bus.out_y), 6);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'b10;
    bus.in_a     = 2'd1;
    bus.in_b     = 2'd2;
    tick();
    tick();
    check("blocked_count", int'(bus.count), DEPTH);
    bus.out_ready = 1'b1;
    tick();
    check("pop_cycle_count", int'(bus.count), DEPTH - 1);
    check("pop_cycle_in_ready", int'(bus.in_ready), 1);
    tick();
    check("push_after_pop_count", int'(bus.count), DEPTH);
    bus.in_valid = 1'b0;
    drain();

    // Reset while in WAIT with 3 queued.
    bus.out_ready = 1'b0;
    push_req(2'b11, 2'd3, 2'd3);
    push_req(2'b10, 2'd2, 2'd2);
    push_req(2'b00, 2'd1, 2'd1);
    push_req(2'b01, 2'd0, 2'd3);
    check("pre_rst_count", int'(bus.count), 3);
    check("pre_rst_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_count", int'(bus.count), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_alu", int'({bus.alu_sel, bus.alu_a, bus.alu_b}), 0);
    check("mid_rst_out", int'({bus.out_sel, bus.out_y}), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", int'(bus.out_valid), 0);
    end

    // Randomized traffic with random backpressure; pointers wrap many times.
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)));
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          tick();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
